fan_pwm_ramp: RTL and testbench
===============================

// Module: fan_pwm_ramp
// PURPOSE
//  Downstream consumer of the clock-divider tick (one-clk pulse every n cycles of the 1 kHz clk).
//  Each tick steps the fan drive duty one unit towards a target set by on_req/speed_lvl (soft start/stop).
//  Converts the current duty into a glitch-free PWM drive for the fan motor.
//  Reports the ramp state for the display/LED logic.
// PARAMETERS
//  PWM_STEPS  10  PWM period in clk cycles (100 Hz at 1 kHz clk); duty range 0..PWM_STEPS
//  DW         4   duty register width; must hold PWM_STEPS
//  DUTY_L1    3   target duty for speed_lvl=1
//  DUTY_L2    6   target duty for speed_lvl=2
//  DUTY_L3    10  target duty for speed_lvl=3 (full on)
// PORTS
//  clk        in   1   1 kHz system clock; all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  tick       in   1   ramp step enable; 1-clk pulse from the divider (clk_n)
//  on_req     in   1   1 = fan requested on, 0 = ramp down to off
//  speed_lvl  in   2   0 = off, 1..3 = DUTY_L1..DUTY_L3
//  pwm_out    out  1   registered PWM drive
//  cur_duty   out  DW  duty currently being ramped (registered)
//  fan_state  out  2   00 OFF, 01 RAMP_UP, 10 RUN, 11 RAMP_DOWN
//  busy       out  1   1 while in RAMP_UP or RAMP_DOWN
// BEHAVIOUR
//  Reset: cur_duty=0, fan_state=OFF, busy=0, pwm_out=0, PWM counter=0, latched duty=0.
//  Target (combinational): tgt = (on_req && speed_lvl!=0) ? DUTY_Lx : 0.
//  Ramp: tgt and tick are sampled in the same cycle; the update is visible next cycle.
//  -  tick && cur_duty<tgt: cur_duty+1.
//  -  tick && cur_duty>tgt: cur_duty-1.
//  -  tick && cur_duty==tgt: no change.
//  -  No tick: cur_duty is held. Step is exactly +-1 and never leaves 0..PWM_STEPS.
//  FSM (next state is computed from the post-update cur_duty):
//  -  OFF:       tgt>0 -> RAMP_UP.
//  -  RAMP_UP:   cur_duty==tgt -> RUN; tgt<cur_duty -> RAMP_DOWN.
//  -  RUN:       tgt>cur_duty -> RAMP_UP; tgt<cur_duty -> RAMP_DOWN.
//  -  RAMP_DOWN: cur_duty==tgt==0 -> OFF; cur_duty==tgt>0 -> RUN; tgt>cur_duty -> RAMP_UP.
//  A target change mid-ramp reverses direction on the next tick; there is no restart from 0.
//  PWM:
//  -  pwm_cnt runs free 0..PWM_STEPS-1 and wraps.
//  -  duty_lat <= cur_duty only when pwm_cnt==PWM_STEPS-1, so duty changes take effect at a period boundary.
//  -  pwm_out <= (pwm_cnt < duty_lat), i.e. one register stage after the counter.
//  -  duty 0 -> constant 0; duty PWM_STEPS -> constant 1 (no glitch pulse).
//  Reset asserted mid-ramp: all outputs return to reset values on the next edge; the ramp is abandoned.
//  Ticks arriving during rst are ignored.
//  Unknown speed_lvl encodings cannot occur (2 bits, all decoded).
// STRUCTURE
//  Shared package fan_pkg:
//  -  fan_state encoding constants (ST_OFF/ST_RAMP_UP/ST_RUN/ST_RAMP_DOWN).
//  -  speed level codes and DUTY_L1..L3 defaults.
//  -  PWM_STEPS default, so the divider and display stages agree.
//  Sub-module pwm_gen (clk, rst, duty_in, pwm_out):
//  -  contains the free-running counter, period-boundary latch and comparator.
//  fan_pwm_ramp contains the target decode, ramp register and FSM.
// TESTING
//  1 Reset: rst=1 for 3 clk while tick toggles -> pwm_out=0, cur_duty=0, fan_state=00 throughout.
//  2 Soft start: on_req=1, lvl=2, tick every 5 clk.
//    -> cur_duty 1..6, one step per tick; fan_state=01 until duty=6, then 10.
//    -> in RUN, pwm_out high 6 of every 10 clk.
//  3 Reverse mid-ramp: lvl=3 ramping, at duty=4 drop on_req.
//    -> next tick duty=3, state 11; reaches 0 -> state 00, pwm_out constant 0.
//  4 Simultaneous: tick in the same cycle as lvl change 1->3 while RUN at duty 3
//    -> next cycle duty=4, state 01.
//  5 Extremes: duty 10 -> pwm_out constant 1 over 3 periods.
//    A duty change mid-period only alters pwm_out from the next period start.
//  6 Reset mid-ramp: rst pulse at duty=5 during RAMP_UP -> next cycle all outputs reset.
//    After release with on_req still 1, the ramp restarts from 0.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared fan-drive constants: state encoding, speed codes, default duties and PWM period.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fan_pkg;

   // PWM period in clk cycles; duty ranges over 0..PWM_STEPS
   localparam int PWM_STEPS = 10;
   localparam int DW        = 4;

   // Default target duty per speed level
   localparam int DUTY_L1 = 3;
   localparam int DUTY_L2 = 6;
   localparam int DUTY_L3 = 10;

   // speed_lvl encodings (all four are decoded)
   localparam logic [1:0] LVL_OFF = 2'd0;
   localparam logic [1:0] LVL_1   = 2'd1;
   localparam logic [1:0] LVL_2   = 2'd2;
   localparam logic [1:0] LVL_3   = 2'd3;

   // fan_state encoding as seen by the display/LED logic
   typedef enum logic [1:0] {
      ST_OFF       = 2'b00,
      ST_RAMP_UP   = 2'b01,
      ST_RUN       = 2'b10,
      ST_RAMP_DOWN = 2'b11
   } fan_state_t;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running period counter, period-boundary duty latch, registered comparator.
// Latency: pwm_out lags the counter by one clk; a new duty_in takes effect at the next period start.
// Backpressure: none; runs every clk.
module pwm_gen
   import fan_pkg::*;
#(
   parameter int PWM_STEPS_P = PWM_STEPS,
   parameter int DW_P        = DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW_P-1:0] duty_in,
   output logic            pwm_out
);

   localparam logic [DW_P-1:0] CNT_LAST = DW_P'(PWM_STEPS_P - 1);

   logic [DW_P-1:0] pwm_cnt;
   logic [DW_P-1:0] duty_lat;

   // Period counter, duty latch at the last count of a period, and the output compare.
   // Latching only at the boundary keeps each period's high time whole, so no runt pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt  <= '0;
         duty_lat <= '0;
         pwm_out  <= 1'b0;
      end else begin
         if (pwm_cnt == CNT_LAST) begin
            pwm_cnt  <= '0;
            duty_lat <= duty_in;
         end else begin
            pwm_cnt  <= pwm_cnt + DW_P'(1);
         end
         // duty 0 never compares true; duty PWM_STEPS always does, so both extremes are flat
         pwm_out <= (pwm_cnt < duty_lat);
      end
   end

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan soft start/stop: steps duty one unit per tick toward the speed target and drives a PWM output.
// Latency: cur_duty/fan_state/busy update the clk after a tick; pwm_out follows at the next PWM period.
// Backpressure: none; ticks are consumed on arrival, ticks during rst are dropped.
module fan_pwm_ramp
   import fan_pkg::*;
#(
   parameter int PWM_STEPS_P = PWM_STEPS,
   parameter int DW_P        = DW,
   parameter int DUTY_L1_P   = DUTY_L1,
   parameter int DUTY_L2_P   = DUTY_L2,
   parameter int DUTY_L3_P   = DUTY_L3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            on_req,
   input  logic [1:0]      speed_lvl,
   output logic            pwm_out,
   output logic [DW_P-1:0] cur_duty,
   output logic [1:0]      fan_state,
   output logic            busy
);

   logic [DW_P-1:0] tgt;
   logic [DW_P-1:0] nxt_duty;
   fan_state_t      state;

   // Target duty from the request: off unless on_req and a non-zero level
   always_comb begin
      tgt = '0;
      if (on_req) begin
         case (speed_lvl)
            LVL_1:   tgt = DW_P'(DUTY_L1_P);
            LVL_2:   tgt = DW_P'(DUTY_L2_P);
            LVL_3:   tgt = DW_P'(DUTY_L3_P);
            default: tgt = '0;
         endcase
      end
   end

   // One-unit step toward the target on a tick; targets lie within 0..PWM_STEPS so the step stays in range
   always_comb begin
      nxt_duty = cur_duty;
      if (tick) begin
         if (cur_duty < tgt) begin
            nxt_duty = cur_duty + DW_P'(1);
         end else if (cur_duty > tgt) begin
            nxt_duty = cur_duty - DW_P'(1);
         end
      end
   end

   // Ramp register and state machine; next state is judged against the post-step duty
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_duty <= '0;
         state    <= ST_OFF;
         busy     <= 1'b0;
      end else begin
         cur_duty <= nxt_duty;
         case (state)
            ST_OFF: begin
               if (tgt != '0) begin
                  state <= ST_RAMP_UP;
                  busy  <= 1'b1;
               end
            end
            ST_RAMP_UP: begin
               if (nxt_duty == tgt) begin
                  state <= ST_RUN;
                  busy  <= 1'b0;
               end else if (tgt < nxt_duty) begin
                  state <= ST_RAMP_DOWN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (tgt > nxt_duty) begin
                  state <= ST_RAMP_UP;
                  busy  <= 1'b1;
               end else if (tgt < nxt_duty) begin
                  state <= ST_RAMP_DOWN;
                  busy  <= 1'b1;
               end
            end
            ST_RAMP_DOWN: begin
               if (nxt_duty == tgt) begin
                  state <= (tgt == '0) ? ST_OFF : ST_RUN;
                  busy  <= 1'b0;
               end else if (tgt > nxt_duty) begin
                  state <= ST_RAMP_UP;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= ST_OFF;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fan_state = state;

   pwm_gen #(
      .PWM_STEPS_P (PWM_STEPS_P),
      .DW_P        (DW_P)
   ) u_pwm_gen (
      .clk     (clk),
      .rst     (rst),
      .duty_in (cur_duty),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Bench for fan_pwm_ramp: directed scenarios plus random traffic against a behavioural model.
// Latency: model advances once per clk and is compared 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_fan_pwm_ramp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       on_req = 1'b0;
   logic [1:0] speed_lvl = 2'd0;
   logic       pwm_out;
   logic [3:0] cur_duty;
   logic [1:0] fan_state;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;

   // behavioural model state
   int m_duty  = 0;
   int m_state = 0;
   int m_busy  = 0;
   int m_pwm   = 0;
   int m_cnt   = 0;
   int m_lat   = 0;

   fan_pwm_ramp dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .on_req    (on_req),
      .speed_lvl (speed_lvl),
      .pwm_out   (pwm_out),
      .cur_duty  (cur_duty),
      .fan_state (fan_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   function automatic int lvl_duty(input int lvl);
      case (lvl)
         1:       return 3;
         2:       return 6;
         3:       return 10;
         default: return 0;
      endcase
   endfunction

   // One clk of the reference behaviour, using the inputs present at the edge
   task automatic model_edge();
      int tgt, nd, ns, np;
      if (rst) begin
         m_duty = 0; m_state = 0; m_busy = 0; m_pwm = 0; m_cnt = 0; m_lat = 0;
         return;
      end
      tgt = (on_req && speed_lvl != 0) ? lvl_duty(int'(speed_lvl)) : 0;
      nd  = m_duty;
      if (tick && m_duty < tgt) nd = m_duty + 1;
      if (tick && m_duty > tgt) nd = m_duty - 1;
      ns = m_state;
      case (m_state)
         0: if (tgt > 0) ns = 1;
         1: if (nd == tgt) ns = 2; else if (tgt < nd) ns = 3;
         2: if (tgt > nd) ns = 1; else if (tgt < nd) ns = 3;
         default: if (nd == tgt) ns = (tgt == 0) ? 0 : 2; else if (tgt > nd) ns = 1;
      endcase
      np = (m_cnt < m_lat) ? 1 : 0;
      if (m_cnt == 9) m_lat = m_duty;
      m_cnt   = (m_cnt + 1) % 10;
      m_pwm   = np;
      m_duty  = nd;
      m_state = ns;
      m_busy  = (ns == 1 || ns == 3) ? 1 : 0;
   endtask

   // Drive tick for one clk, advance the model, compare every output
   task automatic step(input bit t);
      tick = t;
      @(posedge clk);
      model_edge();
      #1;
      chk("duty",  int'(cur_duty),  m_duty);
      chk("state", int'(fan_state), m_state);
      chk("busy",  int'(busy),      m_busy);
      chk("pwm",   int'(pwm_out),   m_pwm);
      tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0);
      step(1'b1);
      rst = 1'b0;
   endtask

   task automatic count_pwm(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0);
         hi += int'(pwm_out);
      end
   endtask

   initial begin
      int hi;

      // 1: reset held while tick toggles
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(i[0]);
         chk("rst_duty", int'(cur_duty), 0);
         chk("rst_state", int'(fan_state), 0);
         chk("rst_pwm", int'(pwm_out), 0);
      end
      rst = 1'b0;

      // 2: soft start to level 2, a tick every 5 clk
      on_req = 1'b1; speed_lvl = 2'd2;
      for (int k = 1; k <= 6; k++) begin
         for (int j = 0; j < 4; j++) step(1'b0);
         step(1'b1);
         chk("s2_duty", int'(cur_duty), k);
         chk("s2_state", int'(fan_state), (k < 6) ? 1 : 2);
      end
      for (int j = 0; j < 25; j++) step(1'b0);
      count_pwm(10, hi);
      chk("s2_pwm_hi", hi, 6);

      // 3: drop on_req at duty 4 while heading for level 3
      do_reset();
      speed_lvl = 2'd3; on_req = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b1);
      chk("s3_duty4", int'(cur_duty), 4);
      on_req = 1'b0;
      step(1'b1);
      chk("s3_duty3", int'(cur_duty), 3);
      chk("s3_down", int'(fan_state), 3);
      for (int k = 0; k < 3; k++) step(1'b1);
      chk("s3_off", int'(fan_state), 0);
      for (int j = 0; j < 15; j++) step(1'b0);
      count_pwm(10, hi);
      chk("s3_pwm_hi", hi, 0);

      // 4: level change coincides with a tick while running at duty 3
      do_reset();
      on_req = 1'b1; speed_lvl = 2'd1;
      for (int k = 0; k < 3; k++) step(1'b1);
      chk("s4_run", int'(fan_state), 2);
      speed_lvl = 2'd3;
      step(1'b1);
      chk("s4_duty", int'(cur_duty), 4);
      chk("s4_up", int'(fan_state), 1);

      // 5: full duty is a flat high; then a mid-period step down
      for (int k = 0; k < 6; k++) step(1'b1);
      chk("s5_duty", int'(cur_duty), 10);
      for (int j = 0; j < 12; j++) step(1'b0);
      count_pwm(30, hi);
      chk("s5_pwm_hi", hi, 30);
      speed_lvl = 2'd2;
      for (int j = 0; j < 3; j++) step(1'b0);
      step(1'b1);
      chk("s5_mid_pwm", int'(pwm_out), 1);
      for (int j = 0; j < 12; j++) step(1'b0);

      // 6: reset mid-ramp, then restart from 0
      do_reset();
      on_req = 1'b1; speed_lvl = 2'd3;
      for (int k = 0; k < 5; k++) step(1'b1);
      chk("s6_duty5", int'(cur_duty), 5);
      rst = 1'b1;
      step(1'b1);
      chk("s6_rst_duty", int'(cur_duty), 0);
      chk("s6_rst_state", int'(fan_state), 0);
      chk("s6_rst_busy", int'(busy), 0);
      rst = 1'b0;
      step(1'b0);
      step(1'b1);
      chk("s6_restart", int'(cur_duty), 1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) begin
            on_req    = ($urandom_range(0, 3) != 0);
            speed_lvl = 2'($urandom_range(0, 3));
         end
         step($urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
